// File: rtl/ps2_pkg.sv
// Shared PS/2 transmitter definitions: FSM encoding, frame size, default timing.
// No logic of its own; frame builder is a pure function.
package ps2_pkg;

    typedef logic [2:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE  = 3'd0;
    localparam ps2_state_t ST_GAP   = 3'd1;
    localparam ps2_state_t ST_HIGH  = 3'd2;
    localparam ps2_state_t ST_LOW   = 3'd3;
    localparam ps2_state_t ST_DONE  = 3'd4;
    localparam ps2_state_t ST_ABORT = 3'd5;

    localparam int PS2_FRAME_BITS   = 11;
    localparam int PS2_CLK_HALF_DEF = 1920;
    localparam int PS2_IDLE_GAP_DEF = 2400;

    // Bit 0 goes on the wire first: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Scancode FWFT FIFO: head visible while non-empty, level/ready update the cycle after push/pop.
// Pushes while full are dropped (push_rdy low); pop on empty is ignored.
module ps2_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    output logic                     push_rdy,
    input  logic                     pop_vld,
    output logic [W-1:0]             head_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (level != LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push_vld & push_rdy;
    assign do_pop   = pop_vld & ~empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_push && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: buffered scancodes serialised as 11-bit frames.
// First falling edge IDLE_GAP+CLK_HALF+2 cycles after push; host inhibit aborts and resends the frame.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HALF   = PS2_CLK_HALF_DEF,
    parameter int IDLE_GAP   = PS2_IDLE_GAP_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          ps2_clk_i,
    output logic                          ps2_clk_o,
    output logic                          ps2_dat_o,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_MAX = (CLK_HALF > IDLE_GAP) ? CLK_HALF : IDLE_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HALF_LAST   = CW'(CLK_HALF - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(IDLE_GAP);
    localparam logic [CW-1:0] SYNC_SETTLE = CW'(2);
    localparam logic [3:0]    STOP_IDX    = 4'(PS2_FRAME_BITS - 1);
    localparam logic [3:0]    PAR_IDX     = 4'(PS2_FRAME_BITS - 2);

    logic                      clk_meta;
    logic                      clk_sync;
    ps2_state_t                state;
    ps2_state_t                state_nx;
    logic [CW-1:0]             cnt;
    logic [CW-1:0]             cnt_nx;
    logic [3:0]                bit_idx;
    logic [3:0]                idx_nx;
    logic [PS2_FRAME_BITS-1:0] frame;
    logic [PS2_FRAME_BITS-1:0] frame_nx;
    logic                      clk_drv_nx;
    logic                      dat_drv_nx;
    logic                      fifo_pop;
    logic                      fifo_empty;
    logic [7:0]                head_dat;

    ps2_tx_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .push_vld (tx_valid),
        .push_dat (tx_data),
        .push_rdy (tx_ready),
        .pop_vld  (fifo_pop),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign busy = (state != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = bit_idx;
        frame_nx = frame;
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (!fifo_empty) begin
                    state_nx = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!clk_sync) begin
                    cnt_nx = '0;
                end else if (cnt == GAP_LAST) begin
                    state_nx = ST_HIGH;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    frame_nx = ps2_frame(head_dat);
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_HIGH: begin
                // Our own low phase is still in the synchroniser for the first two cycles.
                if (bit_idx <= PAR_IDX && cnt >= SYNC_SETTLE && !clk_sync) begin
                    state_nx = ST_ABORT;
                    cnt_nx   = '0;
                end else if (cnt == HALF_LAST) begin
                    state_nx = ST_LOW;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_LOW: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx = '0;
                    if (bit_idx == STOP_IDX) begin
                        state_nx = ST_DONE;
                    end else begin
                        idx_nx   = bit_idx + 4'd1;
                        state_nx = ST_HIGH;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                fifo_pop = 1'b1;
                state_nx = ST_IDLE;
            end
            ST_ABORT: begin
                cnt_nx   = '0;
                state_nx = ST_GAP;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Line drives are registered from the next state so they are glitch-free yet in step with it.
    assign clk_drv_nx = (state_nx != ST_LOW);
    assign dat_drv_nx = (state_nx == ST_HIGH || state_nx == ST_LOW) ? frame_nx[idx_nx] : 1'b1;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            frame     <= '1;
            ps2_clk_o <= 1'b1;
            ps2_dat_o <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_i;
            clk_sync  <= clk_meta;
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_idx   <= idx_nx;
            frame     <= frame_nx;
            ps2_clk_o <= clk_drv_nx;
            ps2_dat_o <= dat_drv_nx;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: host-side frame decoder feeding a scoreboard, plus directed timing checks.
module tb_ps2_kbd_tx;

    localparam int H = 10;
    localparam int G = 50;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       host_clk;
    logic       ps2_clk_i;
    logic       ps2_clk_o;
    logic       ps2_dat_o;
    logic       busy;
    logic [3:0] fifo_level;

    assign ps2_clk_i = ps2_clk_o & host_clk;

    ps2_kbd_tx #(
        .CLK_HALF   (H),
        .IDLE_GAP   (G),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_clk_o  (ps2_clk_o),
        .ps2_dat_o  (ps2_dat_o),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    int falls       = 0;
    int frames_rx   = 0;
    int bitn        = 0;
    int last_fall   = 0;

    logic [10:0] exp_q [$];
    logic [10:0] rxf;

    // Scancodes with hand-computed odd-parity bits.
    logic [7:0] vbyte [9] = '{8'h1C, 8'hF0, 8'h5A, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h29, 8'h12};
    logic       vpar  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic push(input int i);
        tx_data  = vbyte[i];
        tx_valid = 1'b1;
        exp_q.push_back({1'b1, vpar[i], vbyte[i], 1'b0});
        @(posedge clk_sys);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_falls(input int target, input string name);
        for (int n = 0; n < 4000 && falls < target; n++) tick();
        check(name, int'(falls >= target), 1);
    endtask

    task automatic wait_frames(input int target, input string name);
        for (int n = 0; n < 4000 && frames_rx < target; n++) tick();
        check(name, int'(frames_rx >= target), 1);
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 4000 && busy; n++) tick();
        check(name, int'(busy), 0);
    endtask

    // Host model: samples data on each device-driven falling clock edge.
    initial begin : monitor
        logic        prev;
        logic [10:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk_sys);
            if (prev && !ps2_clk_o) begin
                rxf[bitn] = ps2_dat_o;
                bitn++;
                falls++;
                last_fall = cyc;
                if (bitn == 11) begin
                    bitn = 0;
                    frames_rx++;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL frame: got %h, expected no frame", rxf);
                    end else begin
                        e = exp_q.pop_front();
                        if (rxf !== e) begin
                            miscompares++;
                            $display("FAIL frame: got %h, expected %h", rxf, e);
                        end
                    end
                end
            end else if (bitn != 0 && cyc - last_fall > 3 * H) begin
                bitn = 0;
            end
            prev = ps2_clk_o;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin : stim
        int f0, r0, fa, p, t;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        host_clk = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_clk_o", int'(ps2_clk_o), 1);
        check("rst_dat_o", int'(ps2_dat_o), 1);
        check("rst_ready", int'(tx_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_level", int'(fifo_level), 0);
        reset = 1'b0;
        repeat (5) @(posedge clk_sys);
        #1;

        // Single 0x1C frame on an idle bus.
        f0 = falls;
        r0 = frames_rx;
        push(0);
        p = cyc;
        check("t1_level", int'(fifo_level), 1);
        check("t1_ready", int'(tx_ready), 1);
        check("t1_busy", int'(busy), 1);
        wait_falls(f0 + 1, "t1_first_fall_seen");
        check("t1_first_fall_latency", last_fall - p, G + H + 2);
        wait_frames(r0 + 1, "t1_frame_seen");
        t = last_fall;
        wait_idle("t1_idle");
        check("t1_busy_drop", cyc - t, H + 1);
        repeat (3 * H) tick();
        check("t1_edge_count", falls - f0, 11);
        check("t1_level_empty", int'(fifo_level), 0);

        // Back-to-back 0xF0, 0x1C.
        r0 = frames_rx;
        push(1);
        push(0);
        check("t2_level", int'(fifo_level), 2);
        wait_frames(r0 + 1, "t2_first_frame");
        t  = last_fall;
        fa = falls;
        wait_falls(fa + 1, "t2_second_start");
        check("t2_gap_ok", int'((last_fall - t) >= G + 2 * H), 1);
        wait_frames(r0 + 2, "t2_second_frame");
        wait_idle("t2_idle");

        // Host inhibit during bit 4 of 0x5A.
        r0 = frames_rx;
        push(2);
        f0 = falls;
        wait_falls(f0 + 5, "t3_bit4_reached");
        host_clk = 1'b0;
        for (int n = 0; n <= H + 3 && !(ps2_clk_o && ps2_dat_o); n++) tick();
        check("t3_released_in_time", int'(ps2_clk_o && ps2_dat_o), 1);
        fa = falls;
        repeat (400) tick();
        check("t3_no_edges_held", falls - fa, 0);
        check("t3_level_kept", int'(fifo_level), 1);
        check("t3_lines_released", int'({ps2_clk_o, ps2_dat_o}), 3);
        check("t3_no_frame_yet", frames_rx - r0, 0);
        host_clk = 1'b1;
        t = cyc;
        wait_falls(fa + 1, "t3_restart_seen");
        check("t3_restart_gap_ok", int'((last_fall - t) >= G + H), 1);
        wait_frames(r0 + 1, "t3_resent_frame");
        wait_idle("t3_idle");
        check("t3_level_popped", int'(fifo_level), 0);

        // Inhibit after the 11th falling edge: committed, no retransmit.
        r0 = frames_rx;
        push(3);
        wait_frames(r0 + 1, "t4_frame");
        host_clk = 1'b0;
        repeat (3 * H) tick();
        host_clk = 1'b1;
        wait_idle("t4_idle");
        check("t4_level_popped", int'(fifo_level), 0);
        fa = falls;
        repeat (G + 30 * H) tick();
        check("t4_no_retransmit", falls - fa, 0);
        check("t4_frame_count", frames_rx - r0, 1);

        // Fill while inhibited: ninth byte dropped.
        host_clk = 1'b0;
        r0 = frames_rx;
        for (int i = 0; i < 9; i++) begin
            tx_data  = vbyte[i];
            tx_valid = 1'b1;
            if (i < 8) exp_q.push_back({1'b1, vpar[i], vbyte[i], 1'b0});
            @(posedge clk_sys);
            #1;
            if (i == 7) begin
                check("t5_ready_full", int'(tx_ready), 0);
                check("t5_level_full", int'(fifo_level), 8);
            end
        end
        tx_valid = 1'b0;
        check("t5_level_after_drop", int'(fifo_level), 8);
        repeat (100) tick();
        check("t5_held_level", int'(fifo_level), 8);
        check("t5_held_busy", int'(busy), 1);
        check("t5_held_no_frames", frames_rx - r0, 0);
        host_clk = 1'b1;
        wait_frames(r0 + 8, "t5_all_frames");
        wait_idle("t5_idle");
        check("t5_level_empty", int'(fifo_level), 0);

        // Reset during bit 6 of 0x01 (data low there, clock driven low).
        push(5);
        push(4);
        f0 = falls;
        wait_falls(f0 + 7, "t6_bit6_reached");
        reset = 1'b1;
        #1;
        check("t6_async_lines", int'({ps2_clk_o, ps2_dat_o}), 3);
        check("t6_level", int'(fifo_level), 0);
        check("t6_ready", int'(tx_ready), 1);
        check("t6_busy", int'(busy), 0);
        exp_q.delete();
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b0;
        fa = falls;
        repeat (G + 30 * H) tick();
        check("t6_no_edges", falls - fa, 0);
        check("t6_level_after", int'(fifo_level), 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
